// File: rtl/forwarding_hazard_unit.sv
// Shadow EXE/MEM/WB tag pipeline that drives EXE forwarding selects and load-use stalls.
// Macro FORWARDING_EN enables forwarding; without it selects read 00 and any RAW on EXE/MEM stalls.
module forwarding_hazard_unit #(
  parameter int REG_ADDR_LEN  = 5,
  parameter int STALL_CNT_LEN = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [REG_ADDR_LEN-1:0]  id_src1,
  input  logic                     id_src1_used,
  input  logic [REG_ADDR_LEN-1:0]  id_src2,
  input  logic                     id_src2_used,
  input  logic [REG_ADDR_LEN-1:0]  id_st_src,
  input  logic                     id_is_store,
  input  logic [REG_ADDR_LEN-1:0]  id_dest,
  input  logic                     id_wb_en,
  input  logic                     id_mem_r_en,
  input  logic                     flush,
  output logic [1:0]               val1_sel,
  output logic [1:0]               val2_sel,
  output logic [1:0]               ST_val_sel,
  output logic                     hazard_stall,
  output logic [STALL_CNT_LEN-1:0] stall_count
);
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  typedef struct packed {
    logic [REG_ADDR_LEN-1:0] src1;
    logic [REG_ADDR_LEN-1:0] src2;
    logic [REG_ADDR_LEN-1:0] st_src;
    logic [REG_ADDR_LEN-1:0] dest;
    logic                    src1_used;
    logic                    src2_used;
    logic                    is_store;
    logic                    wb_en;
    logic                    mem_r_en;
  } exe_stage_t;

  typedef struct packed {
    logic [REG_ADDR_LEN-1:0] dest;
    logic                    wb_en;
  } tag_stage_t;

  exe_stage_t               exe_reg, exe_next;
  tag_stage_t               exe_tag, mem_stage_reg, wb_stage_reg;
  logic [STALL_CNT_LEN-1:0] stall_count_reg, stall_count_next;
  logic                     raw_exe;

  // Register 0 is hardwired, so a write to it never produces a forwardable value.
  function automatic logic produces(input tag_stage_t t, input logic [REG_ADDR_LEN-1:0] r);
    return t.wb_en && (t.dest != '0) && (t.dest == r);
  endfunction

  function automatic logic id_raw_on(input tag_stage_t t,
                                     input logic [REG_ADDR_LEN-1:0] s1, s2, st,
                                     input logic u1, u2, ist);
    return (u1 && produces(t, s1)) || (u2 && produces(t, s2)) || (ist && produces(t, st));
  endfunction

  assign exe_tag = {exe_reg.dest, exe_reg.wb_en};
  assign raw_exe = id_raw_on(exe_tag, id_src1, id_src2, id_st_src,
                             id_src1_used, id_src2_used, id_is_store);

`ifdef FORWARDING_EN
  logic [2:0][REG_ADDR_LEN-1:0] opnd_src;
  logic [2:0]                   opnd_used;

  assign opnd_src  = {exe_reg.st_src, exe_reg.src2, exe_reg.src1};
  assign opnd_used = {exe_reg.is_store, exe_reg.src2_used, exe_reg.src1_used};
  assign hazard_stall = id_valid && !flush && exe_reg.mem_r_en && raw_exe;
`else
  logic raw_mem;
  logic unused_nofwd;

  assign raw_mem = id_raw_on(mem_stage_reg, id_src1, id_src2, id_st_src,
                             id_src1_used, id_src2_used, id_is_store);
  // Without forwarding the consumer waits until its producer has reached WB.
  assign hazard_stall = id_valid && !flush && (raw_exe || raw_mem);
  assign unused_nofwd = ^{exe_reg, wb_stage_reg};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sel
      logic [1:0] sel;
`ifdef FORWARDING_EN
      // MEM holds the younger producer, so it wins over WB.
      always_comb begin
        sel = SEL_RF;
        if (opnd_used[gi]) begin
          if (produces(mem_stage_reg, opnd_src[gi])) begin
            sel = SEL_MEM;
          end else if (produces(wb_stage_reg, opnd_src[gi])) begin
            sel = SEL_WB;
          end
        end
      end
`else
      assign sel = SEL_RF;
`endif
    end
  endgenerate

  assign val1_sel   = g_sel[0].sel;
  assign val2_sel   = g_sel[1].sel;
  assign ST_val_sel = g_sel[2].sel;

  always_comb begin
    exe_next = '0;
    if (id_valid && !flush && !hazard_stall) begin
      exe_next.src1      = id_src1;
      exe_next.src2      = id_src2;
      exe_next.st_src    = id_st_src;
      exe_next.dest      = id_dest;
      exe_next.src1_used = id_src1_used;
      exe_next.src2_used = id_src2_used;
      exe_next.is_store  = id_is_store;
      exe_next.wb_en     = id_wb_en;
      exe_next.mem_r_en  = id_mem_r_en;
    end
  end

  always_comb begin
    stall_count_next = stall_count_reg;
    if (hazard_stall && (stall_count_reg != '1)) begin
      stall_count_next = stall_count_reg + STALL_CNT_LEN'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_reg         <= '0;
      mem_stage_reg   <= '0;
      wb_stage_reg    <= '0;
      stall_count_reg <= '0;
    end else begin
      exe_reg         <= exe_next;
      mem_stage_reg   <= exe_tag;
      wb_stage_reg    <= mem_stage_reg;
      stall_count_reg <= stall_count_next;
    end
  end

  assign stall_count = stall_count_reg;
endmodule
